// File: rtl/ariane_pkg.sv
// Shared execute-stage types: writeback payload and default port count.
package ariane_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned NR_WB_PORTS   = 2;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        xlen_t                    result;
        logic                     ex_valid;
    } wb_entry_t;

endpackage

// File: rtl/ex_wb_fifo.sv
// Per-channel writeback result FIFO; strict order, no fall-through, no bypass.
module ex_wb_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  wb_entry_t data_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t data_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t       mem_q [Depth];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [CntW-1:0] cnt_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; flush behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PtrW'(1);
            if (pop_ok)  rd_q <= rd_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO's head is never selected.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ex_wb_arbiter.sv
// Buffers FU results per channel and drains them onto NrWbPorts writeback
// ports with a rotating-priority scan starting at rr_q.
module ex_wb_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NrFu      = 4,
    parameter int unsigned NrWbPorts = NR_WB_PORTS,
    parameter int unsigned Depth     = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NrFu-1:0]                    fu_valid_i,
    output logic [NrFu-1:0]                    fu_ready_o,
    input  logic [NrFu*TRANS_ID_BITS-1:0]      fu_trans_id_i,
    input  logic [NrFu*XLEN-1:0]               fu_result_i,
    input  logic [NrFu-1:0]                    fu_ex_valid_i,
    output logic [NrWbPorts-1:0]               wb_valid_o,
    input  logic [NrWbPorts-1:0]               wb_ready_i,
    output logic [NrWbPorts*TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [NrWbPorts*XLEN-1:0]          wb_result_o,
    output logic [NrWbPorts-1:0]               wb_ex_valid_o,
    output logic [NrWbPorts*$clog2(NrFu)-1:0]  wb_fu_o,
    output logic                               wb_conflict_o
);

    localparam int unsigned FuW  = $clog2(NrFu);
    localparam int unsigned SumW = FuW + 1;
    localparam int unsigned CntW = $clog2(NrFu + 1);

    wb_entry_t              head [NrFu];
    logic [NrFu-1:0]        full;
    logic [NrFu-1:0]        empty;
    logic [NrFu-1:0]        push;
    logic [NrFu-1:0]        pop;
    logic                   block;
    logic [FuW-1:0]         rr_q;
    logic [FuW-1:0]         rr_d;
    logic [FuW-1:0]         grant_fu [NrWbPorts];
    logic [NrWbPorts-1:0]   grant_vld;
    logic [NrWbPorts-1:0]   wb_valid;
    logic [CntW-1:0]        slot;
    logic [SumW-1:0]        sum;
    logic [FuW-1:0]         ch;
    logic                   hit;
    wb_entry_t              sel;

    assign block      = rst_i | flush_i;
    assign fu_ready_o = ~full & {NrFu{~block}};
    assign push       = fu_valid_i & fu_ready_o;

    for (genvar i = 0; i < NrFu; i++) begin : g_fifo
        wb_entry_t din;
        assign din.trans_id = fu_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS];
        assign din.result   = fu_result_i[i*XLEN +: XLEN];
        assign din.ex_valid = fu_ex_valid_i[i];

        ex_wb_fifo #(.Depth(Depth)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (push[i]),
            .data_i  (din),
            .pop_i   (pop[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .data_o  (head[i])
        );
    end

    // Rotating scan: the p-th non-empty channel from rr_q takes port p; slot ends as the non-empty count.
    always_comb begin
        grant_vld = '0;
        slot      = '0;
        sum       = '0;
        ch        = '0;
        hit       = 1'b0;
        for (int p = 0; p < NrWbPorts; p++) grant_fu[p] = '0;
        for (int k = 0; k < NrFu; k++) begin
            sum = {1'b0, rr_q} + SumW'(k);
            if (sum >= SumW'(NrFu)) sum = sum - SumW'(NrFu);
            ch  = sum[FuW-1:0];
            hit = ~empty[ch];
            for (int p = 0; p < NrWbPorts; p++) begin
                if (hit && (slot == CntW'(p))) begin
                    grant_vld[p] = 1'b1;
                    grant_fu[p]  = ch;
                end
            end
            if (hit) slot = slot + CntW'(1);
        end
    end

    // Port outputs, per-channel pops and next rotation pointer.
    always_comb begin
        wb_valid      = '0;
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_valid_o = '0;
        wb_fu_o       = '0;
        pop           = '0;
        rr_d          = rr_q;
        sel           = '0;
        for (int p = 0; p < NrWbPorts; p++) begin
            wb_valid[p] = grant_vld[p] & ~block;
            sel         = wb_valid[p] ? head[grant_fu[p]] : '0;
            wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] = sel.trans_id;
            wb_result_o[p*XLEN +: XLEN]                     = sel.result;
            wb_ex_valid_o[p]                                = sel.ex_valid;
            wb_fu_o[p*FuW +: FuW] = wb_valid[p] ? grant_fu[p] : '0;
            if (wb_valid[p] && wb_ready_i[p]) begin
                for (int c = 0; c < NrFu; c++) begin
                    if (grant_fu[p] == FuW'(c)) pop[c] = 1'b1;
                end
                rr_d = (grant_fu[p] == FuW'(NrFu - 1)) ? '0 : grant_fu[p] + FuW'(1);
            end
        end
    end

    assign wb_valid_o    = wb_valid;
    assign wb_conflict_o = ~block & (slot > CntW'(NrWbPorts));

    always_ff @(posedge clk_i) begin
        if (block) rr_q <= '0;
        else       rr_q <= rr_d;
    end

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Directed bench for ex_wb_arbiter (4 channels, 2 ports, depth 2) with a
// per-channel-ordered scoreboard fed at push acceptance and checked at pop.
module tb_ex_wb_arbiter;
    import ariane_pkg::*;

    localparam int NF = 4;
    localparam int NP = 2;
    localparam int FW = 2;
    localparam int TW = TRANS_ID_BITS;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [NF-1:0]       fu_valid;
    logic [NF-1:0]       fu_ready;
    logic [NF*TW-1:0]    fu_id;
    logic [NF*XLEN-1:0]  fu_res;
    logic [NF-1:0]       fu_ex;
    logic [NP-1:0]       wb_valid;
    logic [NP-1:0]       wb_ready;
    logic [NP*TW-1:0]    wb_id;
    logic [NP*XLEN-1:0]  wb_res;
    logic [NP-1:0]       wb_ex;
    logic [NP*FW-1:0]    wb_fu;
    logic                wb_conflict;

    typedef struct {
        int              ch;
        logic [TW-1:0]   id;
        logic [XLEN-1:0] res;
        logic            ex;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;

    ex_wb_arbiter #(.NrFu(NF), .NrWbPorts(NP), .Depth(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .fu_valid_i    (fu_valid),
        .fu_ready_o    (fu_ready),
        .fu_trans_id_i (fu_id),
        .fu_result_i   (fu_res),
        .fu_ex_valid_i (fu_ex),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_trans_id_o (wb_id),
        .wb_result_o   (wb_res),
        .wb_ex_valid_o (wb_ex),
        .wb_fu_o       (wb_fu),
        .wb_conflict_o (wb_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fu_valid = '0;
        fu_ex    = '0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input int c, input logic [TW-1:0] id, input logic [XLEN-1:0] res, input logic ex);
        fu_valid[c]             = 1'b1;
        fu_id[c*TW +: TW]       = id;
        fu_res[c*XLEN +: XLEN]  = res;
        fu_ex[c]                = ex;
    endtask

    function automatic logic [63:0] pid(input int p);
        return 64'(wb_id[p*TW +: TW]);
    endfunction

    function automatic logic [63:0] pfu(input int p);
        return 64'(wb_fu[p*FW +: FW]);
    endfunction

    // Scoreboard: retire on observed pops (order within a channel), enqueue accepted pushes.
    always @(negedge clk) begin
        if (rst || flush) begin
            sbq.delete();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (wb_valid[p] && wb_ready[p]) begin
                    int found;
                    found = -1;
                    for (int i = 0; i < sbq.size(); i++)
                        if (found < 0 && sbq[i].ch == int'(wb_fu[p*FW +: FW])) found = i;
                    check("sb_hit", 64'(found >= 0), 64'd1);
                    if (found >= 0) begin
                        check("sb_id", pid(p), 64'(sbq[found].id));
                        check("sb_result", wb_res[p*XLEN +: XLEN], sbq[found].res);
                        check("sb_ex", 64'(wb_ex[p]), 64'(sbq[found].ex));
                        sbq.delete(found);
                    end
                end
            end
            for (int c = 0; c < NF; c++) begin
                if (fu_valid[c] && fu_ready[c])
                    sbq.push_back('{c, fu_id[c*TW +: TW], fu_res[c*XLEN +: XLEN], fu_ex[c]});
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_id = '0; fu_res = '0; fu_ex = '0;
        wb_ready = '1;

        // Reset values
        tick(); sample();
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_ready", 64'(fu_ready), 64'd0);
        check("rst_conflict", 64'(wb_conflict), 64'd0);
        check("rst_id", 64'(wb_id), 64'd0);
        check("rst_fu", 64'(wb_fu), 64'd0);
        tick();

        // Basic: single push on ch2
        tick(); rst = 1'b0; push(2, 3'd5, 64'hABCD, 1'b0); sample();
        check("ready_after_rst", 64'(fu_ready), 64'hF);
        tick(); sample();
        check("basic_valid", 64'(wb_valid), 64'b01);
        check("basic_id", pid(0), 64'd5);
        check("basic_fu", pfu(0), 64'd2);
        check("basic_res", wb_res[XLEN-1:0], 64'hABCD);
        tick(); sample();
        check("basic_drained", 64'(wb_valid), 64'd0);

        // Round-robin from rr_q = 0
        tick(); flush = 1'b1; wb_ready = '0; sample();
        tick(); flush = 1'b0;
        for (int c = 0; c < NF; c++) push(c, TW'(c + 1), 64'h100 + 64'(c), c == 3);
        sample();
        tick(); wb_ready = '1; sample();
        check("rr1_valid", 64'(wb_valid), 64'b11);
        check("rr1_fu0", pfu(0), 64'd0);
        check("rr1_fu1", pfu(1), 64'd1);
        check("rr1_conflict", 64'(wb_conflict), 64'd1);
        tick(); sample();
        check("rr2_fu0", pfu(0), 64'd2);
        check("rr2_fu1", pfu(1), 64'd3);
        check("rr2_conflict", 64'(wb_conflict), 64'd0);
        tick(); push(0, 3'd6, 64'h600, 1'b0); push(3, 3'd7, 64'h700, 1'b0); sample();
        check("rr3_idle", 64'(wb_valid), 64'd0);
        tick(); sample();
        check("rr_wrap_fu0", pfu(0), 64'd0);
        check("rr_wrap_fu1", pfu(1), 64'd3);

        // Backpressure on ch1
        tick(); wb_ready = '0; push(1, 3'd1, 64'h11, 1'b0); sample();
        check("bp_ready1", 64'(fu_ready[1]), 64'd1);
        tick(); push(1, 3'd2, 64'h22, 1'b1); sample();
        check("bp_ready2", 64'(fu_ready[1]), 64'd1);
        check("bp_stall_id", pid(0), 64'd1);
        tick(); push(1, 3'd3, 64'h33, 1'b0); sample();
        check("bp_full", 64'(fu_ready[1]), 64'd0);
        tick(); wb_ready = '1; sample();
        check("bp_pop1_id", pid(0), 64'd1);
        check("bp_no_bypass", 64'(fu_ready[1]), 64'd0);
        tick(); sample();
        check("bp_ready_back", 64'(fu_ready[1]), 64'd1);
        check("bp_pop2_id", pid(0), 64'd2);
        tick(); sample();
        check("bp_drained", 64'(wb_valid), 64'd0);

        // Full FIFO with simultaneous pop refuses the push
        tick(); wb_ready = '0; push(0, 3'd6, 64'h66, 1'b0);
        tick(); push(0, 3'd7, 64'h77, 1'b0);
        tick(); wb_ready = 2'b01; push(0, 3'd0, 64'hDEAD, 1'b0); sample();
        check("full_refuse", 64'(fu_ready[0]), 64'd0);
        check("full_head", pid(0), 64'd6);
        tick(); sample();
        check("full_cnt1", 64'(fu_ready[0]), 64'd1);
        check("full_next", pid(0), 64'd7);
        tick(); sample();
        check("full_drained", 64'(wb_valid), 64'd0);

        // Flush with three FIFOs occupied and a concurrent ch3 push
        tick(); wb_ready = '0;
        push(0, 3'd1, 64'hA1, 1'b0); push(1, 3'd2, 64'hA2, 1'b0); push(2, 3'd3, 64'hA3, 1'b0);
        tick(); sample();
        check("fl_conflict_pre", 64'(wb_conflict), 64'd1);
        tick(); flush = 1'b1; push(3, 3'd5, 64'hBAD, 1'b0); sample();
        check("fl_valid", 64'(wb_valid), 64'd0);
        check("fl_conflict", 64'(wb_conflict), 64'd0);
        check("fl_ready", 64'(fu_ready), 64'd0);
        tick(); flush = 1'b0; wb_ready = '1; sample();
        check("fl_after", 64'(wb_valid), 64'd0);
        tick(); push(0, 3'd6, 64'hC6, 1'b0); push(3, 3'd7, 64'hC7, 1'b1); sample();
        check("fl_after2", 64'(wb_valid), 64'd0);
        tick(); sample();
        check("fl_rr_fu0", pfu(0), 64'd0);
        check("fl_rr_fu1", pfu(1), 64'd3);
        check("fl_rr_id1", pid(1), 64'd7);
        tick();

        // Reset during a stalled writeback
        tick(); wb_ready = '0; push(1, 3'd4, 64'hE4, 1'b1);
        tick(); sample();
        check("mr_stalled", 64'(wb_valid), 64'b01);
        tick(); rst = 1'b1; sample();
        check("mr_valid", 64'(wb_valid), 64'd0);
        check("mr_ready", 64'(fu_ready), 64'd0);
        check("mr_res", wb_res[63:0], 64'd0);
        check("mr_fu", 64'(wb_fu), 64'd0);
        tick(); rst = 1'b0; wb_ready = '1; sample();
        check("mr_no_stale", 64'(wb_valid), 64'd0);
        check("mr_ready_back", 64'(fu_ready), 64'hF);
        tick(); sample();
        check("mr_no_stale2", 64'(wb_valid), 64'd0);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
